imem_boot_ctrl: RTL and testbench



---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_byte_store.sv | 53 +++++
 rtl/imem_boot_ctrl.sv | 143 ++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    F_OK       = 2'b00,
    F_MISALIGN = 2'b01,
    F_RANGE    = 2'b10,
    F_NOTREADY = 2'b11
  } fault_e;

  localparam int unsigned BYTES_PER_INSTR = 4;

endpackage

// File: rtl/imem_byte_store.sv
// Byte array with one write port and a registered 4-byte read assembled
// in little- or big-endian order.
module imem_byte_store
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned INSTR_W     = 32,
  parameter bit          BIG_ENDIAN  = 1'b0,
  parameter int unsigned IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [7:0]         wdata,
  input  logic               re,
  input  logic [IDX_W-1:0]   raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [7:0]         mem_q [DEPTH_BYTES];
  logic [INSTR_W-1:0] rdata_q, rdata_d;

  // Contents deliberately not reset so an image survives rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Bytes are placed into fixed lanes (concatenation, never summation).
  always_comb begin
    rdata_d = '0;
    for (int unsigned k = 0; k < BYTES_PER_INSTR; k++) begin
      if (BIG_ENDIAN) begin
        rdata_d[INSTR_W-8*(k+1) +: 8] = mem_q[raddr + IDX_W'(k)];
      end else begin
        rdata_d[8*k +: 8] = mem_q[raddr + IDX_W'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction memory front end: byte-serial boot loader FSM, run gate and
// a registered 32-bit fetch port with fault reporting.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned INSTR_W     = 32,
  parameter bit          BIG_ENDIAN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               boot_start,
  input  logic               boot_valid,
  input  logic [7:0]         boot_data,
  input  logic               boot_last,
  output logic               boot_ready,
  output logic [ADDR_W:0]    load_count,
  output logic               load_overflow,
  output logic               run,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [1:0]         fetch_fault
);

  localparam int unsigned    IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'(DEPTH_BYTES - 1);
  localparam logic [ADDR_W:0] MAX_FETCH = (ADDR_W+1)'(DEPTH_BYTES - BYTES_PER_INSTR);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full_q, full_d;
  logic               fvalid_q;
  fault_e             fault_q, fault_d;
  logic               we;
  logic               rd_en;
  logic [INSTR_W-1:0] rdata;

  // load_count doubles as the write pointer: one byte written per count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    full_d  = full_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (boot_start) begin
          state_d = LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
      LOAD: begin
        if (boot_start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          full_d  = 1'b0;
        end else if (boot_valid) begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
          if (boot_last) begin
            state_d = RUN;
          end else if (count_q == LAST_PTR) begin
            state_d = RUN;
            full_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (boot_start) begin
          state_d = LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
          full_d  = 1'b0;
        end else if (full_q && boot_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q != RUN) begin
      fault_d = F_NOTREADY;
    end else if (fetch_addr[1:0] != 2'b00) begin
      fault_d = F_MISALIGN;
    end else if ({1'b0, fetch_addr} > MAX_FETCH) begin
      fault_d = F_RANGE;
    end else begin
      fault_d = F_OK;
    end
    rd_en = fetch_req && (fault_d == F_OK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fault_q  <= F_OK;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      fvalid_q <= fetch_req;
      fault_q  <= fetch_req ? fault_d : F_OK;
    end
  end

  imem_byte_store #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .INSTR_W     (INSTR_W),
    .BIG_ENDIAN  (BIG_ENDIAN),
    .IDX_W       (IDX_W)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (count_q[IDX_W-1:0]),
    .wdata (boot_data),
    .re    (rd_en),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (rdata)
  );

  assign boot_ready    = (state_q == LOAD);
  assign run           = (state_q == RUN);
  assign load_count    = count_q;
  assign load_overflow = ovf_q;
  assign fetch_valid   = fvalid_q;
  assign fetch_fault   = fault_q;
  assign fetch_instr   = (fvalid_q && fault_q == F_OK) ? rdata : '0;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench: little- and big-endian instances share one stimulus stream.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        boot_start = 1'b0;
  logic        boot_valid = 1'b0;
  logic [7:0]  boot_data = 8'h00;
  logic        boot_last = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;

  logic        ready_le, ovf_le, run_le, fv_le;
  logic [16:0] cnt_le;
  logic [31:0] instr_le;
  logic [1:0]  fault_le;
  logic        ready_be, ovf_be, run_be, fv_be;
  logic [16:0] cnt_be;
  logic [31:0] instr_be;
  logic [1:0]  fault_be;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.ADDR_W(16), .DEPTH_BYTES(1024), .INSTR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .boot_valid(boot_valid),
    .boot_data(boot_data), .boot_last(boot_last), .boot_ready(ready_le),
    .load_count(cnt_le), .load_overflow(ovf_le), .run(run_le),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fv_le),
    .fetch_instr(instr_le), .fetch_fault(fault_le)
  );

  imem_boot_ctrl #(.ADDR_W(16), .DEPTH_BYTES(1024), .INSTR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .boot_valid(boot_valid),
    .boot_data(boot_data), .boot_last(boot_last), .boot_ready(ready_be),
    .load_count(cnt_be), .load_overflow(ovf_be), .run(run_be),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fv_be),
    .fetch_instr(instr_be), .fetch_fault(fault_be)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic [16:0] cnt,
                            input logic ovf, input logic rn);
    chk({tag, " boot_ready"}, 32'(ready_le), 32'(rdy));
    chk({tag, " load_count"}, 32'(cnt_le), 32'(cnt));
    chk({tag, " load_overflow"}, 32'(ovf_le), 32'(ovf));
    chk({tag, " run"}, 32'(run_le), 32'(rn));
    chk({tag, " run_be"}, 32'(run_be), 32'(rn));
  endtask

  task automatic chk_fetch_idle(input string tag);
    chk({tag, " fetch_valid"}, 32'(fv_le), 32'd0);
    chk({tag, " fetch_instr"}, instr_le, 32'd0);
    chk({tag, " fetch_fault"}, 32'(fault_le), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = last;
    @(negedge clk);
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic pulse_start();
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] exp_le,
                       input logic [31:0] exp_be, input logic [1:0] exp_f,
                       input bit check_instr);
    string t;
    t = $sformatf("fetch@%0d", a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_req = 1'b0;
    chk({t, " valid"}, 32'(fv_le), 32'd1);
    chk({t, " fault_le"}, 32'(fault_le), 32'(exp_f));
    chk({t, " fault_be"}, 32'(fault_be), 32'(exp_f));
    if (check_instr) begin
      chk({t, " instr_le"}, instr_le, exp_le);
      chk({t, " instr_be"}, instr_be, exp_be);
    end
    @(negedge clk);
    chk({t, " valid_drop"}, 32'(fv_le), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk_status("reset", 1'b0, 17'd0, 1'b0, 1'b0);
    chk_fetch_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_status("idle", 1'b0, 17'd0, 1'b0, 1'b0);

    fetch(16'd0, 32'd0, 32'd0, 2'b11, 1'b1);

    // First image: two little words 0x20 and 0x21
    pulse_start();
    chk_status("load_start", 1'b1, 17'd0, 1'b0, 1'b0);
    send(8'h20, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk_status("load_mid", 1'b1, 17'd4, 1'b0, 1'b0);
    fetch(16'd0, 32'd0, 32'd0, 2'b11, 1'b1);
    chk("load_fetch boot_ready", 32'(ready_le), 32'd1);
    send(8'h21, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
    chk_status("loaded", 1'b0, 17'd8, 1'b0, 1'b1);

    fetch(16'd0, 32'h0000_0020, 32'h2000_0000, 2'b00, 1'b1);
    fetch(16'd4, 32'h0000_0021, 32'h2100_0000, 2'b00, 1'b1);

    // Back-to-back requests
    fetch_req = 1'b1; fetch_addr = 16'd4;
    @(negedge clk);
    fetch_addr = 16'd0;
    chk("b2b first valid", 32'(fv_le), 32'd1);
    chk("b2b first instr", instr_le, 32'h0000_0021);
    @(negedge clk);
    fetch_req = 1'b0;
    chk("b2b second valid", 32'(fv_le), 32'd1);
    chk("b2b second instr", instr_le, 32'h0000_0020);
    @(negedge clk);
    chk("b2b drop", 32'(fv_le), 32'd0);

    fetch(16'd2,    32'd0, 32'd0, 2'b01, 1'b1);
    fetch(16'd1020, 32'd0, 32'd0, 2'b00, 1'b0);
    fetch(16'd1024, 32'd0, 32'd0, 2'b10, 1'b1);
    fetch(16'd1023, 32'd0, 32'd0, 2'b01, 1'b1);
    fetch(16'hFFFC, 32'd0, 32'd0, 2'b10, 1'b1);

    // Overflow: 1024 bytes without boot_last, then one more offered
    pulse_start();
    chk_status("reload_start", 1'b1, 17'd0, 1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      boot_valid = 1'b1;
      boot_data  = 8'(i);
      @(negedge clk);
    end
    boot_data = 8'hAA;
    #1;
    chk_status("full", 1'b0, 17'd1024, 1'b0, 1'b1);
    @(negedge clk);
    boot_valid = 1'b0;
    chk_status("overflow", 1'b0, 17'd1024, 1'b1, 1'b1);
    fetch(16'd1020, 32'hFFFE_FDFC, 32'hFCFD_FEFF, 2'b00, 1'b1);
    fetch(16'd0,    32'h0302_0100, 32'h0001_0203, 2'b00, 1'b1);

    // Reload from RUN, then reset after three bytes
    pulse_start();
    chk_status("run_reload", 1'b1, 17'd0, 1'b0, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    chk_status("partial", 1'b1, 17'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_status("mid_reset", 1'b0, 17'd0, 1'b0, 1'b0);
    chk_fetch_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(16'd0, 32'd0, 32'd0, 2'b11, 1'b1);

    // Start with a simultaneous byte: that byte must be dropped
    boot_start = 1'b1; boot_valid = 1'b1; boot_data = 8'h99;
    @(negedge clk);
    boot_start = 1'b0; boot_valid = 1'b0;
    chk_status("start_with_byte", 1'b1, 17'd0, 1'b0, 1'b0);
    send(8'h44, 1'b0); send(8'h33, 1'b0); send(8'h22, 1'b0); send(8'h11, 1'b1);
    chk_status("reloaded", 1'b0, 17'd4, 1'b0, 1'b1);
    fetch(16'd0, 32'h1122_3344, 32'h4433_2211, 2'b00, 1'b1);
    fetch(16'd4, 32'h0706_0504, 32'h0405_0607, 2'b00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
